// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the 8-bit accumulator processor: field widths
//   (shared with the instruction register), opcode values, ALU operation
//   codes and the control-unit state encoding.
//   Helper functions:
//     is_legal_op(op) - 1 when op is one of the defined opcodes
//     alu_sel(op)     - ALU operation used when the accumulator loads for op
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam int OP_W   = 8;
   localparam int ADDR_W = 8;

   localparam logic [OP_W-1:0] OP_NOP = 8'h00;
   localparam logic [OP_W-1:0] OP_LDA = 8'h01;
   localparam logic [OP_W-1:0] OP_STA = 8'h02;
   localparam logic [OP_W-1:0] OP_ADD = 8'h03;
   localparam logic [OP_W-1:0] OP_SUB = 8'h04;
   localparam logic [OP_W-1:0] OP_JMP = 8'h05;
   localparam logic [OP_W-1:0] OP_JZ  = 8'h06;
   localparam logic [OP_W-1:0] OP_HLT = 8'hFF;

   localparam logic [1:0] ALU_PASS = 2'b00;
   localparam logic [1:0] ALU_ADD  = 2'b01;
   localparam logic [1:0] ALU_SUB  = 2'b10;

   typedef enum logic [3:0] {
      ST_RESET   = 4'd0,
      ST_F_ADDR  = 4'd1,
      ST_F_READ  = 4'd2,
      ST_DECODE  = 4'd3,
      ST_E_ADDR  = 4'd4,
      ST_E_READ  = 4'd5,
      ST_E_WRITE = 4'd6,
      ST_JUMP    = 4'd7,
      ST_HALT    = 4'd8
   } cu_state_e;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      logic legal;
      legal = 1'b0;
      case (op)
         OP_NOP, OP_LDA, OP_STA, OP_ADD, OP_SUB,
         OP_JMP, OP_JZ, OP_HLT: legal = 1'b1;
         default:               legal = 1'b0;
      endcase
      return legal;
   endfunction

   function automatic logic [1:0] alu_sel(input logic [OP_W-1:0] op);
      logic [1:0] sel;
      sel = ALU_PASS;
      case (op)
         OP_ADD:  sel = ALU_ADD;
         OP_SUB:  sel = ALU_SUB;
         default: sel = ALU_PASS;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/control_unit.sv
// ----------------------------------------------------------------------------
// control_unit
//   Fetch/decode/execute sequencer for the accumulator processor. A single
//   state register drives every strobe; the memory handshake (mem_ready)
//   only qualifies the completing-cycle strobes of the waiting states.
//
//   Ports:
//     clk, rst        clock (rising edge), synchronous active-high reset
//     opcode          IR opcode field (sampled only in DECODE)
//     acc_zero        accumulator == 0 flag (sampled only in DECODE)
//     mem_ready       memory access completes this cycle
//     pc_valid/pc_inc/pc_load        program counter controls
//     ir_load/ir_valid               instruction register controls
//     mar_load                       memory address register capture
//     mem_read/mem_write             memory requests
//     acc_valid/acc_load/alu_op      accumulator controls, ALU select
//     halted                         sticky halt indicator
//     illegal                        one-cycle undefined-opcode pulse
//
//   Handshake: a memory access is requested by holding mem_read or
//   mem_write (with its address/data drivers) for as many cycles as it
//   takes; the access completes in the cycle mem_ready=1 while requested.
//   mem_ready in any other cycle is ignored.
// ----------------------------------------------------------------------------
module control_unit
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [OP_W-1:0] opcode,
   input  logic            acc_zero,
   input  logic            mem_ready,
   output logic            pc_valid,
   output logic            pc_inc,
   output logic            pc_load,
   output logic            ir_load,
   output logic            ir_valid,
   output logic            mar_load,
   output logic            mem_read,
   output logic            mem_write,
   output logic            acc_valid,
   output logic            acc_load,
   output logic [1:0]      alu_op,
   output logic            halted,
   output logic            illegal
);

   cu_state_e       state_q, state_d;
   logic [OP_W-1:0] op_q,    op_d;

   // ---------------------------------------------------------------------
   // State register and opcode latch
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RESET;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // The JZ decision uses acc_zero in the DECODE cycle itself; the sampled
   // flag is then carried by the choice of JUMP vs F_ADDR, so later flag
   // changes cannot affect the branch.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         ST_RESET:  state_d = ST_F_ADDR;
         ST_F_ADDR: state_d = ST_F_READ;
         ST_F_READ: begin
            if (mem_ready) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            op_d = opcode;
            case (opcode)
               OP_LDA, OP_STA, OP_ADD, OP_SUB: state_d = ST_E_ADDR;
               OP_JMP:                         state_d = ST_JUMP;
               OP_JZ:   state_d = acc_zero ? ST_JUMP : ST_F_ADDR;
               OP_HLT:                         state_d = ST_HALT;
               default:                        state_d = ST_F_ADDR;
            endcase
         end
         ST_E_ADDR:  state_d = (op_q == OP_STA) ? ST_E_WRITE : ST_E_READ;
         ST_E_READ: begin
            if (mem_ready) state_d = ST_F_ADDR;
         end
         ST_E_WRITE: begin
            if (mem_ready) state_d = ST_F_ADDR;
         end
         ST_JUMP:    state_d = ST_F_ADDR;
         ST_HALT:    state_d = ST_HALT;
         default:    state_d = ST_RESET;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output decode from the registered state
   // ---------------------------------------------------------------------
   always_comb begin
      pc_valid  = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      ir_load   = 1'b0;
      ir_valid  = 1'b0;
      mar_load  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      acc_valid = 1'b0;
      acc_load  = 1'b0;
      alu_op    = ALU_PASS;
      halted    = 1'b0;
      illegal   = 1'b0;
      case (state_q)
         ST_F_ADDR: begin
            pc_valid = 1'b1;
            mar_load = 1'b1;
         end
         ST_F_READ: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_load = 1'b1;
               pc_inc  = 1'b1;
            end
         end
         ST_DECODE:  illegal = ~is_legal_op(opcode);
         ST_E_ADDR: begin
            ir_valid = 1'b1;
            mar_load = 1'b1;
         end
         ST_E_READ: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               acc_load = 1'b1;
               alu_op   = alu_sel(op_q);
            end
         end
         ST_E_WRITE: begin
            acc_valid = 1'b1;
            mem_write = 1'b1;
         end
         ST_JUMP: begin
            ir_valid = 1'b1;
            pc_load  = 1'b1;
         end
         ST_HALT:    halted = 1'b1;
         default: ;
      endcase
   end

endmodule
